fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. It owns the program counter, drives the address into the byte-addressed instruction memory, and registers the returned word into the IF/ID pipeline register. It applies stall, branch/jump redirect and fault handling, so the decode stage sees only a valid instruction or a NOP bubble. It sits directly upstream of the instruction memory and directly feeds decode.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined RISC-V core. Owns the program
// counter, presents it to the byte-addressed instruction memory and registers
// the returned word into the IF/ID pipeline register. Stall, redirect and
// fetch-fault handling are applied here, so decode only ever sees a valid
// instruction or a NOP bubble.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   stall        in   hazard-unit hold request (load-use)
//   redirect     in   taken branch/jump pulse from downstream
//   redirect_pc  in   redirect target, sampled when redirect=1
//   imem_pc      out  fetch address (= current pc)
//   imem_stall   out  stall to instruction memory (memory returns 0 when high)
//   imem_inst    in   instruction word, combinational from imem_pc
//   if_id_pc     out  PC of the registered instruction
//   if_id_inst   out  registered instruction
//   if_id_valid  out  1 = real instruction, 0 = bubble
//   fetch_fault  out  sticky fault flag
//   fetch_count  out  number of valid instructions delivered to IF/ID
//   debug_state  out  current FSM state (0 = RUN, 1 = HALT)
//
// Handshake: there is no valid/ready pair at this boundary. IF/ID is written
// on every rising edge unless stall holds it; if_id_valid qualifies the word
// and a bubble is always NOP_INST with if_id_pc = 0.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1156,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  output logic        imem_stall,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic        debug_state
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // Last legal byte address of the instruction memory, widened to 33 bits so
  // the comparison below is done without any wrap-around.
  localparam logic [32:0] LAST_BYTE = 33'(IMEM_BYTES) - 33'd1;

  // pc + 3 computed in 33 bits: a pc near 2^32 carries into bit 32 and is
  // therefore always out of range instead of wrapping back to a low address.
  logic [32:0] pc_end;
  logic        pc_in_range;

  assign pc_end      = {1'b0, pc} + 33'd3;
  assign pc_in_range = (pc_end <= LAST_BYTE);

  // Memory-side outputs are combinational from the registered state.
  assign imem_pc     = pc;
  assign imem_stall  = stall | (state == HALT);
  assign debug_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            // Redirect wins over a simultaneous stall. A misaligned target
            // is a fault; otherwise the target is fetched next cycle and the
            // current slot becomes a bubble (one-cycle penalty).
            if_id_pc    <= 32'h0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= HALT;
            end else begin
              pc <= redirect_pc;
            end
          end else if (stall) begin
            // Hold pc, IF/ID and the counter. imem_inst is forced to zero by
            // the memory while stalled and is deliberately not sampled.
            pc <= pc;
          end else if (!pc_in_range) begin
            // Fetch would run past the end of memory: halt with pc held.
            if_id_pc    <= 32'h0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= HALT;
          end else begin
            if_id_pc    <= pc;
            if_id_inst  <= imem_inst;
            if_id_valid <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end

        HALT: begin
          // Terminal until reset: bubbles every cycle, inputs ignored.
          if_id_pc    <= 32'h0;
          if_id_inst  <= NOP_INST;
          if_id_valid <= 1'b0;
          fetch_fault <= 1'b1;
        end

        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a table of directed vectors (reset, run, stall,
// redirect, misaligned redirect, end-of-memory, 33-bit range check, reset in
// HALT and during stall) followed by a randomized stall/redirect sequence
// checked against a small reference model. Expected results go into exp_q
// when a cycle is driven and are popped and compared one edge later.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc, imem_inst, if_id_pc, if_id_inst, fetch_count;
  logic        imem_stall, if_id_valid, fetch_fault, debug_state;

  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_pc     (imem_pc),
    .imem_stall  (imem_stall),
    .imem_inst   (imem_inst),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count),
    .debug_state (debug_state)
  );

  // Instruction memory model: word content derived from the address, zero
  // while stalled.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_inst = imem_stall ? 32'h0 : mem_word(imem_pc);

  // Expected post-edge state
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        fault;
    logic [31:0] count;
    logic [31:0] ipc;
    logic        istall;
  } exp_t;
  localparam int EW = $bits(exp_t);

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    exp_t        exp;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc,
                     input logic [31:0] pc, input logic [31:0] inst, input logic valid,
                     input logic fault, input logic [31:0] count, input logic [31:0] ipc,
                     input logic istall);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
    v.exp = '{pc: pc, inst: inst, valid: valid, fault: fault, count: count, ipc: ipc, istall: istall};
    vecs.push_back(v);
  endtask

  // Scoreboard compare of one popped expectation against the DUT.
  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s scoreboard: queue empty", tag);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    chk({tag, " if_id_pc"},    if_id_pc,            e.pc);
    chk({tag, " if_id_inst"},  if_id_inst,          e.inst);
    chk({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
    chk({tag, " fetch_fault"}, {31'h0, fetch_fault}, {31'h0, e.fault});
    chk({tag, " fetch_count"}, fetch_count,         e.count);
    chk({tag, " imem_pc"},     imem_pc,             e.ipc);
    chk({tag, " imem_stall"},  {31'h0, imem_stall},  {31'h0, e.istall});
  endtask

  // Driver: apply inputs, push expectation, take one edge, compare #1 later.
  task automatic drive(input logic rst, input logic stl, input logic rdr,
                       input logic [31:0] rpc, input exp_t e, input string tag);
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  // Reference model for the random phase (pc kept well inside memory).
  logic [31:0] m_pc, m_ipc, m_inst, m_cnt;
  logic        m_valid;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    //   rst stl rdr rpc            if_id_pc      inst                valid flt count ipc          istall
    add(1, 0, 0, 32'h0,           32'h0,        NOP,                0, 0, 0, 32'h0,        0); // reset
    add(0, 0, 0, 32'h0,           32'h0,        mem_word(32'h0),    1, 0, 1, 32'h4,        0); // A
    add(0, 0, 0, 32'h0,           32'h4,        mem_word(32'h4),    1, 0, 2, 32'h8,        0); // B
    add(0, 1, 0, 32'h0,           32'h4,        mem_word(32'h4),    1, 0, 2, 32'h8,        1); // stall 1
    add(0, 1, 0, 32'h0,           32'h4,        mem_word(32'h4),    1, 0, 2, 32'h8,        1); // stall 2
    add(0, 0, 0, 32'h0,           32'h8,        mem_word(32'h8),    1, 0, 3, 32'hC,        0); // C
    add(0, 0, 0, 32'h0,           32'hC,        mem_word(32'hC),    1, 0, 4, 32'h10,       0);
    add(0, 1, 1, 32'h40,          32'h0,        NOP,                0, 0, 4, 32'h40,       1); // redirect+stall
    add(0, 0, 0, 32'h0,           32'h40,       mem_word(32'h40),   1, 0, 5, 32'h44,       0);
    add(0, 0, 1, 32'h42,          32'h0,        NOP,                0, 1, 5, 32'h44,       1); // misaligned
    add(0, 0, 0, 32'h0,           32'h0,        NOP,                0, 1, 5, 32'h44,       1);
    add(0, 1, 1, 32'h80,          32'h0,        NOP,                0, 1, 5, 32'h44,       1); // ignored in HALT
    add(1, 0, 0, 32'h0,           32'h0,        NOP,                0, 0, 0, 32'h0,        0); // reset in HALT
    add(0, 0, 0, 32'h0,           32'h0,        mem_word(32'h0),    1, 0, 1, 32'h4,        0);
    add(0, 1, 0, 32'h0,           32'h0,        mem_word(32'h0),    1, 0, 1, 32'h4,        1);
    add(1, 1, 0, 32'h0,           32'h0,        NOP,                0, 0, 0, 32'h0,        1); // reset in stall
    add(0, 0, 0, 32'h0,           32'h0,        mem_word(32'h0),    1, 0, 1, 32'h4,        0);
    add(0, 0, 1, 32'd1148,        32'h0,        NOP,                0, 0, 1, 32'd1148,     0); // near end
    add(0, 0, 0, 32'h0,           32'd1148,     mem_word(32'd1148), 1, 0, 2, 32'd1152,     0);
    add(0, 0, 0, 32'h0,           32'd1152,     mem_word(32'd1152), 1, 0, 3, 32'd1156,     0); // last legal
    add(0, 0, 0, 32'h0,           32'h0,        NOP,                0, 1, 3, 32'd1156,     1); // out of range
    add(0, 0, 0, 32'h0,           32'h0,        NOP,                0, 1, 3, 32'd1156,     1);
    add(1, 0, 0, 32'h0,           32'h0,        NOP,                0, 0, 0, 32'h0,        0);
    add(0, 0, 1, 32'hFFFF_FFFC,   32'h0,        NOP,                0, 0, 0, 32'hFFFF_FFFC, 0); // wrap test
    add(0, 0, 0, 32'h0,           32'h0,        NOP,                0, 1, 0, 32'hFFFF_FFFC, 1);
    add(1, 0, 0, 32'h0,           32'h0,        NOP,                0, 0, 0, 32'h0,        0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    // Random stall/redirect run from reset state.
    m_pc = 32'h0; m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_cnt = 32'h0;
    for (int c = 0; c < 60; c++) begin
      logic s, r;
      logic [31:0] t;
      exp_t e;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      t = 32'($urandom_range(0, 250)) << 2;
      if (r) begin
        m_pc = t; m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0;
      end else if (!s) begin
        m_ipc = m_pc; m_inst = mem_word(m_pc); m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
      e = '{pc: m_ipc, inst: m_inst, valid: m_valid, fault: 1'b0, count: m_cnt, ipc: m_pc, istall: s};
      drive(1'b0, s, r, t, e, $sformatf("rnd%0d", c));
    end

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard leftover: got %0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
